// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared definitions for the 4-digit 7-segment driver.
// Holds the active-low segment patterns (bit order {dp,g,f,e,d,c,b,a}, dp off)
// and the ASCII-to-segment decode function used by sevenseg_decoder.
package sevenseg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_UNDER = 8'hF7;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;
  localparam logic [7:0] SEG_H = 8'h89;
  localparam logic [7:0] SEG_L = 8'hC7;
  localparam logic [7:0] SEG_O = 8'hA3;
  localparam logic [7:0] SEG_P = 8'h8C;
  localparam logic [7:0] SEG_R = 8'hAF;
  localparam logic [7:0] SEG_S = 8'h92;
  localparam logic [7:0] SEG_T = 8'h87;
  localparam logic [7:0] SEG_U = 8'hC1;

  // Returns active-low {g,f,e,d,c,b,a}; anything not in the table is blank.
  function automatic logic [6:0] ascii_to_seg(input logic [7:0] ch);
    logic [7:0] c;
    logic [7:0] p;
    c = ch;
    // Fold lowercase onto uppercase so both cases share one table.
    if (ch >= 8'h61 && ch <= 8'h7A) c = ch - 8'h20;
    case (c)
      8'h30:   p = SEG_0;
      8'h31:   p = SEG_1;
      8'h32:   p = SEG_2;
      8'h33:   p = SEG_3;
      8'h34:   p = SEG_4;
      8'h35:   p = SEG_5;
      8'h36:   p = SEG_6;
      8'h37:   p = SEG_7;
      8'h38:   p = SEG_8;
      8'h39:   p = SEG_9;
      8'h41:   p = SEG_A;
      8'h42:   p = SEG_B;
      8'h43:   p = SEG_C;
      8'h44:   p = SEG_D;
      8'h45:   p = SEG_E;
      8'h46:   p = SEG_F;
      8'h48:   p = SEG_H;
      8'h4C:   p = SEG_L;
      8'h4F:   p = SEG_O;
      8'h50:   p = SEG_P;
      8'h52:   p = SEG_R;
      8'h53:   p = SEG_S;
      8'h54:   p = SEG_T;
      8'h55:   p = SEG_U;
      8'h2D:   p = SEG_DASH;
      8'h5F:   p = SEG_UNDER;
      default: p = SEG_BLANK;
    endcase
    return p[6:0];
  endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder: purely combinational ASCII to 7-segment lookup.
// Ports:
//   i_char  ASCII character code
//   o_seg   active-low segments {g,f,e,d,c,b,a}
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  logic [7:0] i_char,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = ascii_to_seg(i_char);
  end

endmodule

// File: rtl/sevenseg_driver.sv
// sevenseg_driver: time-multiplexed driver for a 4-digit common-anode display.
// A free-running counter selects one digit at a time; its character is decoded
// and the segment/anode pattern is registered, giving one clock of latency.
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   display_0  ASCII char, leftmost digit (an[3])
//   display_1  ASCII char, digit 1
//   display_2  ASCII char, digit 2
//   display_3  ASCII char, rightmost digit (an[0])
//   decplace   index of the digit whose decimal point is lit
//   seg        active-low segments {dp,g,f,e,d,c,b,a}
//   an         active-low anode enables
module sevenseg_driver
  import sevenseg_pkg::*;
#(
  // Must be at least 2; each digit is lit for 2^(REFRESH_BITS-2) clocks.
  parameter int unsigned REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] display_0,
  input  logic [7:0] display_1,
  input  logic [7:0] display_2,
  input  logic [7:0] display_3,
  input  logic [1:0] decplace,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam logic [REFRESH_BITS-1:0] CntOne = REFRESH_BITS'(1);

  logic [REFRESH_BITS-1:0] r_cnt;
  logic [7:0]              r_seg;
  logic [3:0]              r_an;
  logic [1:0]              w_sel;
  logic [7:0]              w_char;
  logic [6:0]              w_seg;

  assign w_sel = r_cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    w_char = display_0;
    unique case (w_sel)
      2'd0: w_char = display_0;
      2'd1: w_char = display_1;
      2'd2: w_char = display_2;
      2'd3: w_char = display_3;
      default: w_char = display_0;
    endcase
  end

  sevenseg_decoder u_decoder (
    .i_char (w_char),
    .o_seg  (w_seg)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_seg <= SEG_BLANK;
      r_an  <= 4'hF;
    end else begin
      r_cnt <= r_cnt + CntOne;
      // Digit k drives an[3-k], so digit 0 is the leftmost position.
      r_an  <= ~(4'b1000 >> w_sel);
      r_seg <= {(decplace != w_sel), w_seg};
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_sevenseg_driver.sv
// Scoreboard bench for sevenseg_driver with REFRESH_BITS=4 (4 clocks per digit).
// Stimulus pushes hand-computed {seg,an} expectations tagged with the clock
// count at which they must hold; a monitor pops and compares on each negedge.
module tb_sevenseg_driver;

  logic       clk;
  logic       rstn;
  logic [7:0] display_0, display_1, display_2, display_3;
  logic [1:0] decplace;
  logic [7:0] seg;
  logic [3:0] an;

  sevenseg_driver #(
    .REFRESH_BITS (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .display_0 (display_0),
    .display_1 (display_1),
    .display_2 (display_2),
    .display_3 (display_3),
    .decplace  (decplace),
    .seg       (seg),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] seg;
    logic [3:0] an;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [7:0] s, input logic [3:0] a,
                       input logic [7:0] es, input logic [3:0] ea);
    checks++;
    if (s !== es || a !== ea) begin
      failures++;
      $display("FAIL %s @%0t: got seg=%h an=%b, want seg=%h an=%b", nm, $time, s, a, es, ea);
    end
  endtask

  // Monitor: compare every expectation due at the current clock count.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: stale entry for cycle %0d, now %0d", mon_e.nm, mon_e.cyc, cyc);
      end else begin
        check(mon_e.nm, seg, an, mon_e.seg, mon_e.an);
      end
    end
  end

  task automatic push(input int c, input logic [7:0] s, input logic [3:0] a, input string nm);
    exp_t e;
    e.cyc = c;
    e.seg = s;
    e.an  = a;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // Pulse reset between edges, load new inputs, and check the async clear.
  task automatic restart(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input logic [7:0] c3, input logic [1:0] dp, output int base);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    display_0 = c0;
    display_1 = c1;
    display_2 = c2;
    display_3 = c3;
    decplace  = dp;
    #1;
    check("async_rst", seg, an, 8'hFF, 4'hF);
    #1;
    rstn = 1'b1;
    base = cyc;
  endtask

  task automatic scan_check(input string nm, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3, input logic [1:0] dp,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e3);
    int base;
    logic [7:0] es [4];
    logic [3:0] ea [4];
    es = '{e0, e1, e2, e3};
    ea = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    restart(c0, c1, c2, c3, dp, base);
    for (int d = 0; d < 4; d++)
      for (int j = 0; j < 4; j++)
        push(base + 1 + 4 * d + j, es[d], ea[d], nm);
    // First slot again after wrap.
    push(base + 17, e0, 4'b0111, {nm, "_wrap"});
    repeat (17) @(negedge clk);
  endtask

  initial begin
    int base;
    rstn = 1'b0;
    decplace = 2'd0;
    display_0 = 8'h00;
    display_1 = 8'h00;
    display_2 = 8'h00;
    display_3 = 8'h00;

    // Held in reset with random inputs: outputs stay off.
    for (int i = 0; i < 3; i++) begin
      display_0 = 8'($urandom);
      display_1 = 8'($urandom);
      display_2 = 8'($urandom);
      display_3 = 8'($urandom);
      decplace  = 2'($urandom);
      @(negedge clk);
      check("reset_hold", seg, an, 8'hFF, 4'hF);
    end

    scan_check("scan_0123", 8'h30, 8'h31, 8'h32, 8'h33, 2'd3, 8'hC0, 8'hF9, 8'hA4, 8'h30);
    scan_check("banner_HELL", "H", "E", "L", "L", 2'd2, 8'h89, 8'h86, 8'h47, 8'hC7);
    scan_check("banner_hell", "h", "e", "l", "l", 2'd2, 8'h89, 8'h86, 8'h47, 8'hC7);
    scan_check("unsupported", "X", 8'h00, 8'hA5, " ", 2'd0, 8'h7F, 8'hFF, 8'hFF, 8'hFF);
    scan_check("mixed_AbCd", "A", "b", "C", "d", 2'd1, 8'h88, 8'h03, 8'hC6, 8'hA1);
    scan_check("symbols", "-", "_", "P", "R", 2'd0, 8'h3F, 8'hF7, 8'h8C, 8'hAF);
    scan_check("digits_5679", "5", "6", "7", "9", 2'd3, 8'h92, 8'h82, 8'hF8, 8'h10);
    scan_check("digits_48FU", "4", "8", "f", "u", 2'd1, 8'h99, 8'h00, 8'h8E, 8'hC1);
    scan_check("letters_OST", "O", "s", "T", "o", 2'd2, 8'hA3, 8'h92, 8'h07, 8'hA3);

    // Async reset while digit 2 is lit, then scan restarts at digit 0.
    restart("0", "1", "2", "3", 2'd3, base);
    push(base + 9, 8'hA4, 4'b1101, "midscan_digit2");
    repeat (9) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midscan_async_rst", seg, an, 8'hFF, 4'hF);
    @(posedge clk);
    #1;
    check("midscan_rst_held", seg, an, 8'hFF, 4'hF);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    base = cyc;
    push(base + 1, 8'hC0, 4'b0111, "resume_digit0");
    push(base + 5, 8'hF9, 4'b1011, "resume_digit1");
    repeat (5) @(negedge clk);

    // Character change while its digit is active shows up one clock later.
    restart("0", "8", "0", "0", 2'd3, base);
    push(base + 5, 8'h80, 4'b1011, "change_before");
    push(base + 6, 8'hBF, 4'b1011, "change_after");
    push(base + 7, 8'hBF, 4'b1011, "change_held");
    repeat (5) @(negedge clk);
    #2;
    display_1 = "-";
    repeat (3) @(negedge clk);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
